// File: rtl/rx_prbs9_ber_checker.sv
// rx_prbs9_ber_checker
//   Per-branch (I or Q) receive BER checker. Picks one of the two T/2 samples
//   of each symbol, slices its sign to a hard bit, self-synchronises a local
//   PRBS9 (x^9 + x^5 + 1) reference to that bit stream, and then counts
//   checked bits and bit errors.
//
// Ports
//   clk          system clock
//   i_reset      asynchronous active-low reset
//   i_valid      sample strobe, one per T/2 sample
//   i_sample     signed T/2 sample from the downsample-by-2 stage
//   i_phase      which of the two samples per symbol is used (0 first, 1 second)
//   i_clear      synchronous clear of all counters, forces SEARCH
//   o_bit        sliced hard bit (held between strobes)
//   o_bit_valid  one-cycle strobe accompanying o_bit
//   o_locked     high while the checker is in CHECK
//   o_bit_count  saturating count of checked bits since the last clear
//   o_err_count  saturating count of bit errors since the last clear

module rx_prbs9_ber_checker #(
    parameter int NB_SAMPLE = 8,
    parameter int NB_CNT    = 32,
    parameter int WIN_LEN   = 128,
    parameter int ERR_THR   = 16,
    parameter int INVERT    = 0
) (
    input  logic                        clk,
    input  logic                        i_reset,
    input  logic                        i_valid,
    input  logic signed [NB_SAMPLE-1:0] i_sample,
    input  logic                        i_phase,
    input  logic                        i_clear,
    output logic                        o_bit,
    output logic                        o_bit_valid,
    output logic                        o_locked,
    output logic [NB_CNT-1:0]           o_bit_count,
    output logic [NB_CNT-1:0]           o_err_count
);

    localparam int NB_WIN = $clog2(WIN_LEN + 1);

    typedef enum logic {
        SEARCH,
        CHECK
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                toggle;
    logic [8:0]          lfsr;
    logic [3:0]          fill;
    logic [NB_WIN-1:0]   win_cnt;
    logic [NB_WIN-1:0]   win_err;
    logic [NB_WIN-1:0]   win_err_inc;
    logic                accept;
    logic                rx_bit;
    logic                pred;
    logic                mismatch;
    logic                fill_done;
    logic [8:0]          fill_shift;
    logic                win_end;
    logic                win_fail;
    logic                unused_sample_lsbs;

    // Only the sign bit matters to the slicer.
    assign unused_sample_lsbs = ^i_sample[NB_SAMPLE-2:0];

    assign accept      = i_valid & ~i_clear & (toggle == i_phase);
    assign rx_bit      = i_sample[NB_SAMPLE-1] ^ (INVERT != 0);
    assign pred        = lfsr[8] ^ lfsr[4];
    assign mismatch    = rx_bit ^ pred;
    assign fill_done   = (fill == 4'd8);
    assign fill_shift  = {lfsr[7:0], rx_bit};
    assign win_err_inc = win_err + NB_WIN'(mismatch);
    assign win_end     = (win_cnt == NB_WIN'(WIN_LEN - 1));
    assign win_fail    = win_end && (int'(win_err_inc) > ERR_THR);

    // State register
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. An all-zero fill would keep the reference stuck at
    // zero forever, so it is refused at entry as well as guarded in CHECK.
    always_comb begin
        state_next = state;
        if (i_clear) begin
            state_next = SEARCH;
        end else begin
            unique case (state)
                SEARCH: begin
                    if (accept && fill_done && (fill_shift != '0)) begin
                        state_next = CHECK;
                    end
                end
                CHECK: begin
                    if (lfsr == '0) begin
                        state_next = SEARCH;
                    end else if (accept && win_fail) begin
                        state_next = SEARCH;
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    // Output logic
    always_comb begin
        o_locked = (state == CHECK);
    end

    // Datapath: phase toggle, slicer output, reference LFSR and counters.
    // The fill counter is returned to 0 once nine bits are in, so it is
    // already 0 whenever CHECK falls back to SEARCH.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            toggle      <= 1'b0;
            o_bit       <= 1'b0;
            o_bit_valid <= 1'b0;
            lfsr        <= '0;
            fill        <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            o_bit_count <= '0;
            o_err_count <= '0;
        end else begin
            if (i_valid) begin
                toggle <= ~toggle;
            end
            o_bit_valid <= accept;
            if (accept) begin
                o_bit <= rx_bit;
            end

            if (i_clear) begin
                fill        <= '0;
                win_cnt     <= '0;
                win_err     <= '0;
                o_bit_count <= '0;
                o_err_count <= '0;
            end else if (accept) begin
                if (state == SEARCH) begin
                    lfsr    <= fill_shift;
                    fill    <= fill_done ? 4'd0 : fill + 4'd1;
                    win_cnt <= '0;
                    win_err <= '0;
                end else begin
                    // Self-running reference: feed back the prediction.
                    lfsr <= {lfsr[7:0], pred};
                    if (o_bit_count != '1) begin
                        o_bit_count <= o_bit_count + NB_CNT'(1);
                    end
                    if (mismatch && (o_err_count != '1)) begin
                        o_err_count <= o_err_count + NB_CNT'(1);
                    end
                    if (win_end) begin
                        win_cnt <= '0;
                        win_err <= '0;
                    end else begin
                        win_cnt <= win_cnt + NB_WIN'(1);
                        win_err <= win_err_inc;
                    end
                end
            end
        end
    end

endmodule
